keypad_scan4x4: RTL and testbench

KEYPAD_SCAN4X4 -- requirements
Module: keypad_scan4x4

---
 rtl/keypad_scan4x4.sv | 110 +++++++++++
 tb/tb_keypad_scan4x4.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4: 4x4 matrix keypad scanner with debounce, single-entry key buffer and overflow flag.
module keypad_scan4x4 #(
  parameter int STABLE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_tick,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  localparam logic [3:0] STABLE = 4'(STABLE_SCANS);
  state_t     state, state_d;
  logic [1:0] row_idx, row_d, cand_row, cand_row_d;
  logic [3:0] cand_cols, cand_cols_d, cnt, cnt_d, cnt_inc;
  logic [3:0] col_m, col_s, emit_code;
  logic       emit;
  function automatic logic [1:0] low_idx(input logic [3:0] c);
    return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_m     <= 4'hF;
      col_s     <= 4'hF;
      state     <= SCAN;
      row_idx   <= 2'd0;
      cnt       <= 4'd0;
      cand_row  <= 2'd0;
      cand_cols <= 4'hF;
    end else begin
      col_m     <= col_n;
      col_s     <= col_m;
      state     <= state_d;
      row_idx   <= row_d;
      cnt       <= cnt_d;
      cand_row  <= cand_row_d;
      cand_cols <= cand_cols_d;
    end
  assign cnt_inc = (cnt >= STABLE) ? STABLE : cnt + 4'd1;
  always_comb begin
    state_d     = state;
    row_d       = row_idx;
    cnt_d       = cnt;
    cand_row_d  = cand_row;
    cand_cols_d = cand_cols;
    emit        = 1'b0;
    if (scan_tick)
      case (state)
        SCAN:
          if (&col_s) row_d = row_idx + 2'd1;
          else begin
            cand_row_d  = row_idx;
            cand_cols_d = col_s;
            cnt_d       = 4'd1;
            emit        = STABLE <= 4'd1;
            state_d     = emit ? HELD : DEBOUNCE;
          end
        DEBOUNCE:
          if (col_s != cand_cols) begin
            state_d = SCAN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_inc;
            emit    = cnt_inc >= STABLE;
            state_d = emit ? HELD : DEBOUNCE;
          end
        HELD:
          if (&col_s) begin
            state_d = (STABLE <= 4'd1) ? SCAN : RELEASE;
            cnt_d   = (STABLE <= 4'd1) ? 4'd0 : 4'd1;
            row_d   = (STABLE <= 4'd1) ? row_idx + 2'd1 : row_idx;
          end
        RELEASE:
          if (!(&col_s)) begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end else if (cnt_inc >= STABLE) begin
            state_d = SCAN;
            cnt_d   = 4'd0;
            row_d   = row_idx + 2'd1;
          end else cnt_d = cnt_inc;
      endcase
  end
  // Emitting paths latch the candidate on the same edge, so the _d copy is always the right key.
  assign emit_code = {cand_row_d, low_idx(cand_cols_d)};
  always_comb begin
    row_n    = ~(4'b0001 << row_idx);
    key_held = (state == HELD) || (state == RELEASE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= emit && key_valid && !key_ready;
      if (emit && (!key_valid || key_ready)) begin
        key_code  <= emit_code;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) key_valid <= 1'b0;
    end
  a_row_onehot: assert property (@(posedge clk) $onehot(~row_n));
  a_code_stable: assert property (@(posedge clk) disable iff (!rst_n)
    key_valid && !key_ready |=> $stable(key_code));
endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb_keypad_scan4x4: directed table and corner-case sequences for keypad_scan4x4 with a keypad matrix model.
module tb_keypad_scan4x4;
  logic       clk = 1'b0, rst_n = 1'b0, scan_tick = 1'b0, key_ready = 1'b0;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n, key_code;
  logic       key_valid, key_held, overflow;
  logic [3:0] keys [4];
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'hF;
  int         checks = 0, failures = 0, hs_cnt = 0, ovf_cnt = 0;
  int         hs0, ovf0;
  typedef struct {logic [1:0] row; logic [3:0] cols; logic [3:0] code;} vec_t;
  vec_t       vt [8];
  always #5 clk = ~clk;
  keypad_scan4x4 #(.STABLE_SCANS(4)) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) hs_cnt <= hs_cnt + 1;
    if (overflow) ovf_cnt <= ovf_cnt + 1;
  end
  function automatic logic [3:0] model();
    logic [3:0] c;
    c = 4'hF;
    for (int i = 0; i < 4; i++) if (!row_n[i]) c = c & ~keys[i];
    return ovr_en ? ovr_val : c;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick_r(input bit rdy);
    repeat (7) begin
      @(negedge clk);
      col_n = model();
    end
    @(negedge clk);
    col_n = model();
    scan_tick = 1'b1;
    if (rdy) key_ready = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    if (rdy) key_ready = 1'b0;
    col_n = model();
  endtask
  task automatic tick();
    tick_r(1'b0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_held(input logic lvl, input int max, input string name);
    int n;
    n = 0;
    while (key_held !== lvl && n < max) begin
      tick();
      n++;
    end
    chk(name, key_held, lvl);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) keys[i] = 4'h0;
    ovr_en = 1'b0;
    key_ready = 1'b0;
    col_n = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) keys[i] = 4'h0;
    vt[0] = '{2'd0, 4'b0001, 4'h0};
    vt[1] = '{2'd1, 4'b0010, 4'h5};
    vt[2] = '{2'd2, 4'b0100, 4'hA};
    vt[3] = '{2'd3, 4'b1000, 4'hF};
    vt[4] = '{2'd3, 4'b0110, 4'hD};
    vt[5] = '{2'd2, 4'b1000, 4'hB};
    vt[6] = '{2'd0, 4'b1111, 4'h0};
    vt[7] = '{2'd1, 4'b1001, 4'h4};
    repeat (2) @(negedge clk);
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    // single key row2/col1 with consumer always ready
    keys[2] = 4'b0010;
    key_ready = 1'b1;
    hs0 = hs_cnt;
    ticks(5);
    chk("pre_emit_held", key_held, 0);
    tick();
    chk("emit_held", key_held, 1);
    chk("emit_valid", key_valid, 1);
    chk("emit_code", key_code, 4'h9);
    ticks(4);
    chk("still_held", key_held, 1);
    keys[2] = 4'h0;
    ticks(3);
    chk("release_held3", key_held, 1);
    tick();
    chk("release_held4", key_held, 0);
    chk("release_row_adv", row_n, 4'b0111);
    chk("one_pulse", 8'(hs_cnt - hs0), 1);
    key_ready = 1'b0;
    // table of single and multi-column presses
    do_reset();
    for (int v = 0; v < 8; v++) begin
      keys[vt[v].row] = vt[v].cols;
      wait_held(1'b1, 12, "tbl_press");
      chk("tbl_code", key_code, vt[v].code);
      chk("tbl_valid", key_valid, 1);
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      chk("tbl_consume", key_valid, 0);
      keys[vt[v].row] = 4'h0;
      wait_held(1'b0, 8, "tbl_release");
    end
    // bounce on col0 during row1
    do_reset();
    ovr_en = 1'b1;
    ovr_val = 4'hF;
    tick();
    chk("bnc_row1", row_n, 4'b1101);
    ovr_val = 4'b1110;
    tick();
    ovr_val = 4'hF;
    tick();
    chk("bnc_no_adv", row_n, 4'b1101);
    ovr_val = 4'b1110;
    tick();
    ovr_val = 4'hF;
    tick();
    chk("bnc_abort", row_n, 4'b1101);
    tick();
    chk("bnc_scan", row_n, 4'b1011);
    chk("bnc_valid", key_valid, 0);
    chk("bnc_held", key_held, 0);
    ovr_en = 1'b0;
    // two keys with no consumer: second is dropped
    do_reset();
    ovf0 = ovf_cnt;
    keys[0] = 4'b0001;
    wait_held(1'b1, 12, "ovf_a_press");
    keys[0] = 4'h0;
    wait_held(1'b0, 8, "ovf_a_release");
    keys[1] = 4'b0100;
    wait_held(1'b1, 12, "ovf_b_press");
    chk("ovf_pulse", overflow, 1);
    @(negedge clk);
    chk("ovf_pulse_end", overflow, 0);
    chk("ovf_code_kept", key_code, 4'h0);
    chk("ovf_valid", key_valid, 1);
    chk("ovf_count", 8'(ovf_cnt - ovf0), 1);
    keys[1] = 4'h0;
    wait_held(1'b0, 8, "ovf_b_release");
    // handshake and emit on the same edge
    keys[2] = 4'b1000;
    ticks(3);
    chk("same_pre_held", key_held, 0);
    ovf0 = ovf_cnt;
    hs0 = hs_cnt;
    tick_r(1'b1);
    chk("same_valid", key_valid, 1);
    chk("same_code", key_code, 4'hB);
    chk("same_held", key_held, 1);
    @(negedge clk);
    chk("same_no_ovf", 8'(ovf_cnt - ovf0), 0);
    chk("same_hs", 8'(hs_cnt - hs0), 1);
    keys[2] = 4'h0;
    wait_held(1'b0, 8, "same_release");
    // row0 with two low columns, held long
    do_reset();
    key_ready = 1'b1;
    hs0 = hs_cnt;
    keys[0] = 4'b1010;
    ticks(10);
    chk("multi_held", key_held, 1);
    chk("multi_code", key_code, 4'h1);
    chk("multi_once", 8'(hs_cnt - hs0), 1);
    key_ready = 1'b0;
    // asynchronous reset while a key is held and pending
    do_reset();
    keys[3] = 4'b0001;
    wait_held(1'b1, 12, "arst_press");
    chk("arst_pre_valid", key_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    keys[3] = 4'h0;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_held", key_held, 0);
    chk("arst_row_n", row_n, 4'b1110);
    chk("arst_code", key_code, 4'h0);
    chk("arst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_resume_row0", row_n, 4'b1110);
    tick();
    chk("arst_resume_row1", row_n, 4'b1101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
